// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: sends a DATA_WIDTH-bit word as back-to-back 8-bit characters
// with selectable byte order, parity, stop bits, inter-character gap and run-time baud rate.
module uart_frame_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_WIDTH = 32,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  send_en,
    input  logic [2:0]            baud_set,
    output logic                  uart_tx,
    output logic                  tx_done,
    output logic                  uart_state
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    function automatic logic [31:0] bit_period(input logic [2:0] sel);
        case (sel)
            3'd0:    bit_period = 32'(CLK_FREQ / 9600);
            3'd1:    bit_period = 32'(CLK_FREQ / 19200);
            3'd2:    bit_period = 32'(CLK_FREQ / 38400);
            3'd3:    bit_period = 32'(CLK_FREQ / 57600);
            3'd4:    bit_period = 32'(CLK_FREQ / 115200);
            3'd5:    bit_period = 32'(CLK_FREQ / 230400);
            3'd6:    bit_period = 32'(CLK_FREQ / 460800);
            3'd7:    bit_period = 32'(CLK_FREQ / 921600);
            default: bit_period = 32'(CLK_FREQ / 9600);
        endcase
    endfunction

    function automatic logic parity_even(input logic [7:0] b);
        parity_even = ^b;
    endfunction

    // Byte idx counts characters in transmission order; MSB_FIRST maps it onto the word.
    function automatic logic [7:0] byte_at(input logic [DATA_WIDTH-1:0] d, input logic [BW-1:0] idx);
        logic [DATA_WIDTH-1:0] sh;
        int                    pos;
        pos = (MSB_FIRST != 0) ? (NBYTES - 1 - int'(idx)) : int'(idx);
        if (int'(idx) >= NBYTES) begin
            byte_at = 8'h00;
        end else begin
            sh      = d >> (8 * pos);
            byte_at = sh[7:0];
        end
    endfunction

    state_t                state_r, state_nx_s;
    logic [DATA_WIDTH-1:0] data_r, data_nx_s;
    logic [2:0]            baud_r, baud_nx_s;
    logic [31:0]           cnt_r, cnt_nx_s;
    logic [15:0]           bit_r, bit_nx_s;
    logic [BW-1:0]         byte_r, byte_nx_s;
    logic [7:0]            shift_r, shift_nx_s;
    logic                  busy_r, busy_nx_s;
    logic                  done_r, done_nx_s;
    logic                  tx_r, tx_nx_s;

    logic [31:0]           bp_s;
    logic                  bit_end_s;
    logic                  last_byte_s;
    logic [7:0]            cur_byte_s;
    logic [7:0]            nxt_byte_s;
    logic                  par_bit_s;

    assign bp_s        = bit_period(baud_r);
    assign bit_end_s   = (cnt_r == (bp_s - 32'd1));
    assign last_byte_s = (byte_r == BW'(NBYTES - 1));
    assign cur_byte_s  = byte_at(data_r, byte_r);
    assign nxt_byte_s  = byte_at(data_r, byte_r + BW'(1));
    assign par_bit_s   = (PARITY == 2) ? ~parity_even(cur_byte_s) : parity_even(cur_byte_s);

    // State and datapath registers; line value is computed for the next state so it aligns with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            data_r  <= {DATA_WIDTH{1'b0}};
            baud_r  <= 3'd0;
            cnt_r   <= 32'd0;
            bit_r   <= 16'd0;
            byte_r  <= {BW{1'b0}};
            shift_r <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            data_r  <= data_nx_s;
            baud_r  <= baud_nx_s;
            cnt_r   <= cnt_nx_s;
            bit_r   <= bit_nx_s;
            byte_r  <= byte_nx_s;
            shift_r <= shift_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
            tx_r    <= tx_nx_s;
        end
    end

    // Next-state logic. An accepted send spends one IDLE cycle with busy set before START,
    // so the start bit appears one clock after the accepting edge.
    always_comb begin
        state_nx_s = state_r;
        data_nx_s  = data_r;
        baud_nx_s  = baud_r;
        cnt_nx_s   = cnt_r + 32'd1;
        bit_nx_s   = bit_r;
        byte_nx_s  = byte_r;
        shift_nx_s = shift_r;
        busy_nx_s  = busy_r;
        done_nx_s  = 1'b0;
        tx_nx_s    = 1'b1;
        case (state_r)
            S_IDLE: begin
                cnt_nx_s = 32'd0;
                bit_nx_s = 16'd0;
                if (busy_r) begin
                    state_nx_s = S_START;
                    shift_nx_s = cur_byte_s;
                    tx_nx_s    = 1'b0;
                end else if (send_en) begin
                    data_nx_s = data;
                    baud_nx_s = baud_set;
                    busy_nx_s = 1'b1;
                    byte_nx_s = {BW{1'b0}};
                end else begin
                    busy_nx_s = 1'b0;
                end
            end
            S_START: begin
                tx_nx_s = 1'b0;
                if (bit_end_s) begin
                    cnt_nx_s   = 32'd0;
                    state_nx_s = S_DATA;
                    tx_nx_s    = shift_r[0];
                end else begin
                    cnt_nx_s = cnt_r + 32'd1;
                end
            end
            S_DATA: begin
                tx_nx_s = shift_r[0];
                if (bit_end_s) begin
                    cnt_nx_s   = 32'd0;
                    shift_nx_s = shift_r >> 1;
                    if (bit_r == 16'd7) begin
                        bit_nx_s = 16'd0;
                        if (PARITY != 0) begin
                            state_nx_s = S_PARITY;
                            tx_nx_s    = par_bit_s;
                        end else begin
                            state_nx_s = S_STOP;
                            tx_nx_s    = 1'b1;
                        end
                    end else begin
                        bit_nx_s = bit_r + 16'd1;
                        tx_nx_s  = shift_r[1];
                    end
                end else begin
                    cnt_nx_s = cnt_r + 32'd1;
                end
            end
            S_PARITY: begin
                tx_nx_s = par_bit_s;
                if (bit_end_s) begin
                    cnt_nx_s   = 32'd0;
                    bit_nx_s   = 16'd0;
                    state_nx_s = S_STOP;
                    tx_nx_s    = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + 32'd1;
                end
            end
            S_STOP: begin
                tx_nx_s = 1'b1;
                if (bit_end_s) begin
                    cnt_nx_s = 32'd0;
                    if (bit_r == 16'(STOP_BITS - 1)) begin
                        bit_nx_s = 16'd0;
                        if (last_byte_s) begin
                            state_nx_s = S_IDLE;
                            busy_nx_s  = 1'b0;
                            done_nx_s  = 1'b1;
                        end else if (GAP_BITS > 0) begin
                            byte_nx_s  = byte_r + BW'(1);
                            state_nx_s = S_GAP;
                        end else begin
                            byte_nx_s  = byte_r + BW'(1);
                            state_nx_s = S_START;
                            shift_nx_s = nxt_byte_s;
                            tx_nx_s    = 1'b0;
                        end
                    end else begin
                        bit_nx_s = bit_r + 16'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 32'd1;
                end
            end
            S_GAP: begin
                tx_nx_s = 1'b1;
                if (bit_end_s) begin
                    cnt_nx_s = 32'd0;
                    if (bit_r == 16'(GAP_BITS - 1)) begin
                        bit_nx_s   = 16'd0;
                        state_nx_s = S_START;
                        shift_nx_s = cur_byte_s;
                        tx_nx_s    = 1'b0;
                    end else begin
                        bit_nx_s = bit_r + 16'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 32'd1;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                cnt_nx_s   = 32'd0;
                bit_nx_s   = 16'd0;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    assign uart_tx    = tx_r;
    assign tx_done    = done_r;
    assign uart_state = busy_r;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Randomized bench for uart_frame_tx: five configurations share one clock; each word's expected
// line waveform is built as a bit list from the framing rules and compared clock by clock.
module tb_uart_frame_tx;

    localparam int N      = 5;
    localparam int CLK_HZ = 50000000;
    localparam int NB  [N] = '{4, 4, 1, 1, 4};
    localparam int MSB [N] = '{0, 1, 0, 0, 0};
    localparam int PAR [N] = '{0, 0, 1, 2, 0};
    localparam int STP [N] = '{1, 1, 1, 1, 2};
    localparam int GAP [N] = '{0, 0, 0, 0, 3};
    localparam int RATES[8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]       send_p;
    logic [N-1:0][31:0] data_p;
    logic [N-1:0][2:0]  baud_p;
    logic [N-1:0]       tx_p;
    logic [N-1:0]       done_p;
    logic [N-1:0]       state_p;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    uart_frame_tx #(.DATA_WIDTH(32)) u0 (
        .clk(clk), .rst(rst), .data(data_p[0]), .send_en(send_p[0]), .baud_set(baud_p[0]),
        .uart_tx(tx_p[0]), .tx_done(done_p[0]), .uart_state(state_p[0]));
    uart_frame_tx #(.DATA_WIDTH(32), .MSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .data(data_p[1]), .send_en(send_p[1]), .baud_set(baud_p[1]),
        .uart_tx(tx_p[1]), .tx_done(done_p[1]), .uart_state(state_p[1]));
    uart_frame_tx #(.DATA_WIDTH(8), .PARITY(1)) u2 (
        .clk(clk), .rst(rst), .data(data_p[2][7:0]), .send_en(send_p[2]), .baud_set(baud_p[2]),
        .uart_tx(tx_p[2]), .tx_done(done_p[2]), .uart_state(state_p[2]));
    uart_frame_tx #(.DATA_WIDTH(8), .PARITY(2)) u3 (
        .clk(clk), .rst(rst), .data(data_p[3][7:0]), .send_en(send_p[3]), .baud_set(baud_p[3]),
        .uart_tx(tx_p[3]), .tx_done(done_p[3]), .uart_state(state_p[3]));
    uart_frame_tx #(.DATA_WIDTH(32), .STOP_BITS(2), .GAP_BITS(3)) u4 (
        .clk(clk), .rst(rst), .data(data_p[4]), .send_en(send_p[4]), .baud_set(baud_p[4]),
        .uart_tx(tx_p[4]), .tx_done(done_p[4]), .uart_state(state_p[4]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: plain word; 1: send held 3 clk plus ignored mid-frame send with new data/baud;
    // 2: re-send in the tx_done cycle (next word passed as nxt_*); 3: reset during byte 2 data.
    // pre=1 means the send was already accepted by the previous call.
    task automatic run_word(input int k, input logic [31:0] word, input logic [2:0] baud,
                            input int mode, input bit pre,
                            input logic [31:0] nxt_word, input logic [2:0] nxt_baud);
        bit   q[$];
        int   bp, d, cpb, rst_c, bad_line, bad_ctl, first_bad, quiet;
        bit   aborted;
        logic [7:0] ch;
        bp = CLK_HZ / RATES[baud];
        for (int i = 0; i < NB[k]; i++) begin
            int bi;
            bi = (MSB[k] != 0) ? (NB[k] - 1 - i) : i;
            ch = word[8*bi +: 8];
            q.push_back(1'b0);
            for (int j = 0; j < 8; j++) q.push_back(ch[j]);
            if (PAR[k] != 0) q.push_back((^ch) ^ (PAR[k] == 2));
            for (int s = 0; s < STP[k]; s++) q.push_back(1'b1);
            if (i < NB[k] - 1) for (int g = 0; g < GAP[k]; g++) q.push_back(1'b1);
        end
        d         = q.size() * bp;
        cpb       = 10 + ((PAR[k] != 0) ? 1 : 0) + STP[k] - 1 + GAP[k];
        rst_c     = (2 * cpb + 3) * bp + bp / 2;
        bad_line  = 0;
        bad_ctl   = 0;
        first_bad = -1;
        aborted   = 1'b0;
        if (!pre) begin
            @(posedge clk); #1;
            data_p[k] = word;
            baud_p[k] = baud;
            send_p[k] = 1'b1;
            @(posedge clk); #1;
        end
        check($sformatf("accept k%0d", k), {state_p[k], tx_p[k], done_p[k]}, 32'h6);
        if (mode != 1) send_p[k] = 1'b0;
        for (int c = 0; c <= d + 1; c++) begin
            @(posedge clk); #1;
            if (c < d) begin
                if (tx_p[k] !== q[c / bp]) begin
                    bad_line++;
                    if (first_bad < 0) first_bad = c;
                end
                if (state_p[k] !== 1'b1 || done_p[k] !== 1'b0) bad_ctl++;
            end else if (c == d) begin
                check($sformatf("done_at k%0d", k), {done_p[k], state_p[k], tx_p[k]}, 32'h5);
                if (mode == 2) begin
                    data_p[k] = nxt_word;
                    baud_p[k] = nxt_baud;
                    send_p[k] = 1'b1;
                end
            end else begin
                check($sformatf("done_pulse k%0d", k), {done_p[k], tx_p[k]}, 32'h1);
                if (mode == 2) send_p[k] = 1'b0;
            end
            if (mode == 1 && c == 1) send_p[k] = 1'b0;
            if (mode == 1 && c == d / 2) begin
                send_p[k] = 1'b1;
                data_p[k] = $urandom;
                baud_p[k] = 3'($urandom);
            end
            if (mode == 1 && c == d / 2 + 1) send_p[k] = 1'b0;
            if (mode == 3 && c == rst_c) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check($sformatf("rst_abort k%0d", k), {tx_p[k], state_p[k], done_p[k]}, 32'h4);
                rst   = 1'b0;
                quiet = 0;
                repeat (d) begin
                    @(posedge clk); #1;
                    if (done_p[k] !== 1'b0 || tx_p[k] !== 1'b1 || state_p[k] !== 1'b0) quiet++;
                end
                check($sformatf("rst_quiet k%0d", k), quiet, 32'd0);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check($sformatf("line k%0d first_bad_clk=%0d", k, first_bad), bad_line, 32'd0);
            check($sformatf("busy_ctl k%0d", k), bad_ctl, 32'd0);
        end
        if (mode == 1) begin
            quiet = 0;
            repeat (3 * bp) begin
                @(posedge clk); #1;
                if (tx_p[k] !== 1'b1 || state_p[k] !== 1'b0) quiet++;
            end
            check($sformatf("single_word k%0d", k), quiet, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] w;
        rst    = 1'b1;
        send_p = '0;
        data_p = '0;
        baud_p = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++)
            check($sformatf("reset k%0d", k), {tx_p[k], done_p[k], state_p[k]}, 32'h4);
        rst = 1'b0;

        run_word(0, 32'h01234567, 3'd4, 0, 1'b0, 32'h0, 3'd0);
        repeat (2) run_word(0, $urandom, 3'd7, 0, 1'b0, 32'h0, 3'd0);

        w = $urandom;
        run_word(1, 32'h12345678, 3'd7, 2, 1'b0, w, 3'd7);
        run_word(1, w, 3'd7, 0, 1'b1, 32'h0, 3'd0);

        run_word(2, 32'h00000067, 3'd4, 0, 1'b0, 32'h0, 3'd0);
        run_word(3, 32'h00000067, 3'd4, 0, 1'b0, 32'h0, 3'd0);
        run_word(2, {24'h0, 8'($urandom)}, 3'd7, 0, 1'b0, 32'h0, 3'd0);
        run_word(3, {24'h0, 8'($urandom)}, 3'd7, 0, 1'b0, 32'h0, 3'd0);

        run_word(4, 32'h23456789, 3'd4, 0, 1'b0, 32'h0, 3'd0);
        run_word(4, $urandom, 3'd7, 0, 1'b0, 32'h0, 3'd0);

        run_word(0, $urandom, 3'd7, 1, 1'b0, 32'h0, 3'd0);

        run_word(0, 32'hA5C30F96, 3'd7, 3, 1'b0, 32'h0, 3'd0);
        run_word(0, $urandom, 3'd7, 0, 1'b0, 32'h0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised multi-byte UART transmitter. Serialises a DATA_WIDTH-bit word as DATA_WIDTH/8 back-to-back 8-bit UART characters on one line. Adds configurable byte order, optional parity, 1 or 2 stop bits, an inter-byte idle gap and a run-time baud select. Sits between register/bus logic and the board TX pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
DATA_WIDTH, 32, word width; must be a multiple of 8, min 8. NBYTES = DATA_WIDTH/8.
MSB_FIRST, 0, byte order. 0: data[7:0] goes first. 1: data[DATA_WIDTH-1:DATA_WIDTH-8] goes first.
PARITY, 0, parity mode. 0: none. 1: even. 2: odd.
STOP_BITS, 1, stop bits per character; legal values 1 or 2.
GAP_BITS, 0, idle bit-times inserted between characters. Never inserted after the last character.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
data  input  DATA_WIDTH  word to send; captured when a send is accepted
send_en  input  1  start request; sampled each clk edge
baud_set  input  3  baud select, captured with data. 0:9600, 1:19200, 2:38400, 3:57600, 4:115200, 5:230400, 6:460800, 7:921600
uart_tx  output  1  serial line; idles high
tx_done  output  1  one-cycle pulse when the whole word has been sent
uart_state  output  1  1 while a word is in flight

Behaviour:
- Reset (rst=1 at an edge): uart_tx=1, tx_done=0, uart_state=0, FSM=IDLE, all counters 0. Applies mid-frame too. The frame is aborted, uart_tx is 1 from the next edge, and no tx_done is issued.
- Bit period: BP = CLK_FREQ/baud, integer truncation; each bit is held for exactly BP clocks. Divider counts 0..BP-1 and is rebuilt from the captured baud_set only.
- Accept: in IDLE, send_en=1 at edge N captures data and baud_set and sets uart_state=1. uart_tx=0 (start bit) from edge N+1.
- send_en while uart_state=1 is ignored; nothing is queued. data and baud_set changes during a frame have no effect.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> (GAP if GAP_BITS>0 and not last byte) -> START of next byte, or IDLE after the last byte.
- START: 1 bit of 0.
- DATA: 8 bits, LSB first within the character.
- PARITY: even mode sends XOR of the 8 bits; odd mode sends its inverse.
- STOP: STOP_BITS bits of 1.
- GAP: GAP_BITS bits of 1.
- Byte counter runs 0..NBYTES-1. The byte is selected by the counter and MSB_FIRST; the shift register reloads at START entry.
- Completion: at the edge ending the last stop bit of byte NBYTES-1, the FSM enters IDLE, uart_state=0 and tx_done=1 for that one cycle. uart_tx stays 1.
- send_en=1 in the tx_done cycle is accepted: the FSM is IDLE, and the new start bit begins on the next edge. There is no extra idle bit beyond the stop bits.
- Word duration: NBYTES*(10+(PARITY!=0)+(STOP_BITS-1))*BP + (NBYTES-1)*GAP_BITS*BP clocks, counted from the first start-bit clock to tx_done.
- uart_tx is registered; no combinational path from inputs to outputs.

Test Plan:
1. Defaults, baud_set=4 (BP=434), data=0x01234567, send_en pulsed 1 clk. Required:
   - characters 0x67, 0x45, 0x23, 0x01 in that order;
   - first character line sequence 0, 1,1,1,0,0,1,1,0, 1;
   - each bit exactly 434 clk;
   - tx_done single pulse 17360 clk after the start-bit falling edge.
2. MSB_FIRST=1, data=0x12345678. Required:
   - characters 0x12, 0x34, 0x56, 0x78;
   - send_en re-pulsed 1 ns after tx_done rises and held 20 ns;
   - next start bit begins exactly 1 clk after the tx_done cycle;
   - line stays high only during stop bits between words.
3. PARITY=1, then PARITY=2, DATA_WIDTH=8, data=0x67. Required:
   - parity bit 1 (even) and 0 (odd);
   - frame length 11*BP.
4. STOP_BITS=2, GAP_BITS=3, data=0x23456789. Required:
   - each character ends with 2*BP high;
   - 3*BP extra high between characters;
   - none after the last character;
   - total (4*11 + 3*3)*434 clk.
5. send_en held high for 3 clk, then pulsed mid-frame. Required:
   - exactly one word transmitted;
   - mid-frame pulse ignored;
   - data changed mid-frame does not alter the output.
6. rst=1 during byte 2's data bits. Required:
   - uart_tx=1 and uart_state=0 on the next edge;
   - no tx_done;
   - a fresh send after rst=0 transmits the full word correctly.
